// File: rtl/great_top_ctrl.sv
// great_top_ctrl: single-phase-shift modulator for a dual-active-bridge converter.
// Generates complementary primary/secondary gate patterns, a per-period trigger,
// a mode code and latched DC-link over-voltage protection.
// Optional feature macro: GREAT_TOP_DEADTIME_EN (dead-time blanking of the first
// DT counts of each half period). Without it the patterns switch directly.
module great_top_ctrl #(
   parameter int PERIOD   = 1000,
   parameter int DT       = 10,
   parameter int PHI_GAIN = 4000,
   parameter int VMAX     = 3276
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sync,
   input  logic [13:0] Vdc1,
   input  logic [13:0] Vdc2,
   input  logic [13:0] Iref,
   output logic [3:0]  Sp,
   output logic [3:0]  Ss,
   output logic        trigger,
   output logic [1:0]  modo
);

   localparam int CW   = $clog2(PERIOD);
   localparam int HALF = PERIOD / 2;
   localparam int QTR  = PERIOD / 4;

   // Reject parameter sets the counter/pattern logic cannot represent.
   if ((PERIOD % 2) != 0 || DT >= HALF) begin : g_bad_param
      $error("great_top_ctrl: PERIOD must be even and DT < PERIOD/2");
   end

   logic [CW-1:0] pc_q, pc_d;
   logic [CW-1:0] phi_q, phi_d;
   logic          rev_q, rev_d;
   logic          fault_q, fault_d;
   logic [3:0]    sp_q, sp_d, ss_q, ss_d;
   logic          trig_q, trig_d;
   logic [1:0]    modo_q, modo_d;

   logic          ov;
   logic [13:0]   iref_abs;
   logic [31:0]   prod;
   logic [15:0]   phi_raw;
   logic [CW-1:0] phi_new;
   logic [CW:0]   sc_w;
   logic [CW-1:0] sc;

   // Gate pattern for one count: 1001 in the first half, 0110 in the second,
   // optionally blanked at the start of each half.
   function automatic logic [3:0] pattern(input logic [CW-1:0] x);
      logic [3:0] p;
      p = (x < CW'(HALF)) ? 4'b1001 : 4'b0110;
`ifdef GREAT_TOP_DEADTIME_EN
      if (((x < CW'(HALF)) ? x : (x - CW'(HALF))) < CW'(DT)) p = 4'b0000;
`endif
      return p;
   endfunction

   // Over-voltage detect and phase-shift magnitude from the current reference.
   always_comb begin
      ov       = (Vdc1 > 14'(VMAX)) || (Vdc2 > 14'(VMAX));
      iref_abs = Iref[13] ? (~Iref + 14'd1) : Iref;   // -8192 maps to 8192 unsigned
      prod     = 32'(iref_abs) * 32'(PHI_GAIN);
      phi_raw  = prod[31:16];
      phi_new  = (phi_raw > 16'(QTR)) ? CW'(QTR) : phi_raw[CW-1:0];
   end

   // Next-state: fault overrides everything, idle parks the counter, run modulates.
   always_comb begin
      pc_d    = pc_q;
      phi_d   = phi_q;
      rev_d   = rev_q;
      fault_d = fault_q | ov;
      sp_d    = 4'b0000;
      ss_d    = 4'b0000;
      trig_d  = 1'b0;
      modo_d  = 2'd0;
      sc_w    = '0;
      sc      = '0;
      if (fault_d) begin
         pc_d   = '0;
         modo_d = 2'd3;
      end else if (!sync) begin
         pc_d = '0;
      end else begin
         // Reference and direction are only taken at period start.
         if (pc_q == '0) begin
            phi_d = phi_new;
            rev_d = Iref[13];
         end
         if (rev_d) begin
            sc_w = {1'b0, pc_q} + {1'b0, phi_d};
            if (sc_w >= (CW+1)'(PERIOD)) sc_w = sc_w - (CW+1)'(PERIOD);
         end else begin
            sc_w = {1'b0, pc_q} + (CW+1)'(PERIOD) - {1'b0, phi_d};
            if (sc_w >= (CW+1)'(PERIOD)) sc_w = sc_w - (CW+1)'(PERIOD);
         end
         sc     = sc_w[CW-1:0];
         sp_d   = pattern(pc_q);
         ss_d   = pattern(sc);
         trig_d = (pc_q == '0);
         modo_d = rev_d ? 2'd2 : 2'd1;
         pc_d   = (pc_q == CW'(PERIOD-1)) ? '0 : pc_q + CW'(1);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         phi_q   <= '0;
         rev_q   <= 1'b0;
         fault_q <= 1'b0;
         sp_q    <= 4'b0000;
         ss_q    <= 4'b0000;
         trig_q  <= 1'b0;
         modo_q  <= 2'd0;
      end else begin
         pc_q    <= pc_d;
         phi_q   <= phi_d;
         rev_q   <= rev_d;
         fault_q <= fault_d;
         sp_q    <= sp_d;
         ss_q    <= ss_d;
         trig_q  <= trig_d;
         modo_q  <= modo_d;
      end
   end

   assign Sp      = sp_q;
   assign Ss      = ss_q;
   assign trigger = trig_q;
   assign modo    = modo_q;

endmodule

// File: tb/tb_great_top_ctrl.sv
// Bench for great_top_ctrl: cycle-accurate behavioural model checked every clock,
// directed scenarios from the test plan plus randomized reference/sync activity.
module tb_great_top_ctrl;

   localparam int P    = 1000;
   localparam int DT   = 10;
   localparam int G    = 4000;
   localparam int VMAX = 3276;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        sync  = 1'b0;
   logic [13:0] Vdc1  = 14'd2785;
   logic [13:0] Vdc2  = 14'd826;
   logic [13:0] Iref  = 14'd3277;
   logic [3:0]  Sp, Ss;
   logic        trigger;
   logic [1:0]  modo;

   int n_tests = 0;
   int n_fail  = 0;

   // model state: run cycle index since (re)start, per-period phi/direction
   int         m_k = 0, m_phi = 0, m_rev = 0, m_fault = 0;
   logic [3:0] e_sp = 0, e_ss = 0;
   logic       e_trig = 0;
   logic [1:0] e_modo = 0;

   great_top_ctrl dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .Vdc1(Vdc1), .Vdc2(Vdc2), .Iref(Iref),
      .Sp(Sp), .Ss(Ss), .trigger(trigger), .modo(modo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] pat(input int x);
      logic [3:0] p;
      p = (x < P/2) ? 4'b1001 : 4'b0110;
`ifdef GREAT_TOP_DEADTIME_EN
      if ((x % (P/2)) < DT) p = 4'b0000;
`endif
      return p;
   endfunction

   // model update on each edge, then compare shortly after
   initial begin
      int pcm, sc, iv, a;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_k = 0; m_phi = 0; m_rev = 0; m_fault = 0;
            e_sp = 0; e_ss = 0; e_trig = 0; e_modo = 0;
         end else begin
            if (Vdc1 > VMAX || Vdc2 > VMAX) m_fault = 1;
            e_sp = 0; e_ss = 0; e_trig = 0;
            if (m_fault != 0) begin
               e_modo = 3; m_k = 0;
            end else if (!sync) begin
               e_modo = 0; m_k = 0;
            end else begin
               pcm = m_k % P;
               if (pcm == 0) begin
                  iv    = $signed(Iref);
                  a     = (iv < 0) ? -iv : iv;
                  m_phi = (a * G) / 65536;
                  if (m_phi > P/4) m_phi = P/4;
                  m_rev = (iv < 0) ? 1 : 0;
               end
               sc     = (m_rev != 0) ? (pcm + m_phi) % P : (pcm - m_phi + P) % P;
               e_sp   = pat(pcm);
               e_ss   = pat(sc);
               e_trig = (pcm == 0);
               e_modo = (m_rev != 0) ? 2'd2 : 2'd1;
               m_k++;
            end
         end
         #1;
         chk("Sp", Sp, e_sp);
         chk("Ss", Ss, e_ss);
         chk("trigger", trigger, e_trig);
         chk("modo", modo, e_modo);
         chk("overlap", {30'b0, (Sp[0] & Sp[1]) | (Sp[2] & Sp[3]), (Ss[0] & Ss[1]) | (Ss[2] & Ss[3])}, 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cyc(70);                                   // 700 ns in reset
      chk("rst_Sp", Sp, 0);
      chk("rst_Ss", Ss, 0);
      chk("rst_trig", trigger, 0);
      chk("rst_modo", modo, 0);
      rst_n = 1'b1;
      cyc(5);
      chk("idle_modo", modo, 0);
      sync = 1'b1;
      cyc(1);
      chk("first_trig", trigger, 1);
      cyc(1500);
      chk("phi_200", m_phi, 200);
      chk("modo_fwd", modo, 1);

      Iref = 14'h3FFF & 14'(-1638);              // mid-period change
      cyc(200);
      chk("phi_hold", m_phi, 200);
      cyc(1500);
      chk("phi_99", m_phi, 99);
      chk("modo_rev", modo, 2);

      Iref = 14'd6554;
      cyc(2000);
      chk("phi_sat", m_phi, 250);
      chk("modo_fwd2", modo, 1);

      Iref = 14'h2000;                           // -8192
      cyc(1200);
      chk("phi_min_neg", m_phi, 250);
      chk("modo_rev2", modo, 2);

      Iref = 14'd0;
      Vdc2 = 14'(VMAX);                          // equality is not a fault
      cyc(1200);
      chk("phi_zero", m_phi, 0);
      chk("veq_nofault", modo, 1);

      for (int i = 0; i < 12; i++) begin
         Iref = 14'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            sync = 1'b0;
            cyc($urandom_range(1, 30));
            sync = 1'b1;
         end
         cyc($urandom_range(50, 1500));
      end

      sync = 1'b0;                               // drop mid-period
      cyc(1);
      chk("syncoff_Sp", Sp, 0);
      chk("syncoff_modo", modo, 0);
      cyc(20);
      sync = 1'b1;
      cyc(1);
      chk("resync_trig", trigger, 1);

      cyc(437);                                  // async reset mid-period
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_Sp", Sp, 0);
      chk("arst_Ss", Ss, 0);
      chk("arst_modo", modo, 0);
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      chk("rst_restart_trig", trigger, 1);

      cyc(300);
      Vdc1 = 14'd3277;
      cyc(1);
      chk("fault_modo", modo, 3);
      chk("fault_Sp", Sp, 0);
      Vdc1 = 14'd2785;
      Vdc2 = 14'd826;
      cyc(1500);
      chk("fault_sticky", modo, 3);
      sync = 1'b0;
      cyc(10);
      chk("fault_idle", modo, 3);
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      chk("fault_cleared", modo, 0);
      sync = 1'b1;
      cyc(1100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/great_top_ctrl.md
Name: great_top_ctrl

Overview:
- Top-level modulator for a dual-active-bridge DC/DC converter.
- Generates complementary square-wave gate commands for the primary bridge (Sp) and secondary bridge (Ss) using single-phase-shift modulation.
- The phase shift is proportional to the signed current reference Iref.
- Provides a per-period trigger for the ADC/scope, an operating-mode code, and latched over-voltage protection from the DC-link measurements Vdc1/Vdc2.

Parameters:
- PERIOD, 1000, switching period in clk cycles (even; 100 kHz at 100 MHz).
- DT, 10, dead time in clk cycles.
- PHI_GAIN, 4000, phase gain: phi = (|Iref|*PHI_GAIN)>>16 cycles.
- VMAX, 3276, over-voltage threshold in Vdc counts (8.19 counts/V, about 400 V).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- sync  in  1  run enable, level; modulation runs while high.
- Vdc1  in  14  primary DC-link voltage, unsigned counts.
- Vdc2  in  14  secondary DC-link voltage, unsigned counts.
- Iref  in  14  current reference, two's complement, 327.7 counts/A.
- Sp  out  4  primary gates {leg B low, leg B high, leg A low, leg A high}, bit0 = A high.
- Ss  out  4  secondary gates, same bit mapping as Sp.
- trigger  out  1  one-cycle pulse at each period start.
- modo  out  2  mode: 0 idle, 1 forward (Iref>=0), 2 reverse (Iref<0), 3 fault.

Behaviour:
- Reset (async, rst_n=0): Sp=0, Ss=0, trigger=0, modo=0; counter=0; phi=0; fault cleared. All outputs are registered.
- Idle, sync=0:
  - counter held at 0; Sp=Ss=0; trigger=0.
  - modo=0, or 3 if the fault flag is latched.
- Run, sync=1 and no fault:
  - Primary counter pc counts 0..PERIOD-1 and wraps. The first cycle with sync sampled high has pc=0.
  - At pc==0: latch Iref and compute phi = min((|Iref|*PHI_GAIN)>>16, PERIOD/4). The product is at least 27 bits unsigned; |-8192| = 8192.
  - At pc==0: latch direction. modo=1 if Iref>=0, else 2.
  - Iref changes mid-period have no effect until the next pc==0.
  - Secondary count: sc = (pc - phi) mod PERIOD for forward (secondary lags); sc = (pc + phi) mod PERIOD for reverse (secondary leads).
  - Pattern for a count x: first half (x < PERIOD/2) = 4'b1001; second half = 4'b0110.
  - Dead time: for the first DT counts of each half (x mod PERIOD/2 < DT), the pattern is 4'b0000.
  - Sp is the pattern of pc; Ss is the pattern of sc. Each is registered with 1-cycle latency from the counter.
  - trigger=1 for exactly one cycle, aligned with the Sp register reflecting pc==0.
- Invariant: Sp[0]&Sp[1], Sp[2]&Sp[3], Ss[0]&Ss[1] and Ss[2]&Ss[3] are never 1.
- sync falling mid-period: next cycle Sp=Ss=0, counter=0, modo=0. A later rising edge restarts at pc=0.
- Fault:
  - Vdc1>VMAX or Vdc2>VMAX, checked every cycle regardless of sync, sets the fault flag.
  - Next cycle: Sp=Ss=0, trigger=0, modo=3.
  - The flag is sticky until rst_n. Equality with VMAX is not a fault.
- phi=0 (Iref=0): Ss identical to Sp, modo=1.

Optional Feature:
- Macro GREAT_TOP_DEADTIME_EN.
- Defined: dead-time blanking as specified above.
- Undefined: no blanking. Patterns switch directly between 4'b1001 and 4'b0110; DT is ignored. All other behaviour is unchanged.

Test Plan:
- Reset, Vdc1=2785, Vdc2=826, Iref=3277, sync=0 for 700 ns -> Sp=Ss=0, trigger=0, modo=0.
- Raise sync -> trigger pulses every 1000 cycles; Sp=0000 for 10 cycles, then 1001 for 490, then 0000 for 10, then 0110 for 490; modo=1; Ss equals Sp delayed by 200 cycles (phi=200).
- At t=20 µs set Iref=-1638 -> from the next period start modo=2, phi=99, and Ss leads Sp by 99 cycles. The current period is unaffected.
- At t=40 µs set Iref=6554 -> phi saturates at 250; modo=1; Ss lags Sp by 250 cycles.
- Set Vdc1=3277 while running -> one cycle later Sp=Ss=0, modo=3. Restoring Vdc1=2785 keeps the fault until rst_n pulses low.
- Deassert sync mid-period, then reassert; also assert rst_n low mid-period -> outputs 0 immediately (reset) or next cycle (sync); restart at pc=0 with a trigger pulse. Gate-overlap invariant holds throughout.
